// File: rtl/if_slice.sv
// if_slice: instruction fetch stage of the 16-bit 5-stage pipeline.
// Owns the word-addressed PC, drives a req/rdy instruction-memory port,
// keeps one fetched instruction in a skid buffer while decode stalls,
// applies redirects (discarding wrong-path returns) and emits NOP bubbles.
// Optional: define IF_PERF_CNT_EN to add fetch_cnt / bubble_cnt counters.
module if_slice #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'hF000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        hlt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] instr_out,
  output logic [15:0] pc_inc_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] bubble_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DROP      = 3'd1,
    S_FULL      = 3'd2,
    S_HALT_WAIT = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_pend_pc;
  logic [15:0] r_buf_instr;
  logic [15:0] r_buf_pcinc;
  logic [15:0] r_instr;
  logic [15:0] r_pcinc;

  logic [15:0] w_pc_inc;
  logic        w_take_mem;  // memory data goes straight to decode
  logic        w_take_buf;  // skid buffer drains to decode
  logic        w_load_nop;  // decode gets a bubble this cycle

  assign w_pc_inc   = r_pc + 16'd1;
  // The request is live in every state that has (or is about to have) an
  // outstanding access; the pc register doubles as the held address.
  assign imem_req   = ~rst & ((r_state == S_FETCH) | (r_state == S_DROP) |
                              (r_state == S_HALT_WAIT));
  assign imem_addr  = r_pc;
  assign instr_out  = r_instr;
  assign pc_inc_out = r_pcinc;

  // Decide what decode receives this cycle (redirect > hlt > stall).
  always_comb begin
    w_take_mem = 1'b0;
    w_take_buf = 1'b0;
    w_load_nop = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (redirect)      w_load_nop = 1'b1;
        else if (hlt)      w_load_nop = ~stall;
        else if (imem_rdy) w_take_mem = ~stall;
        else               w_load_nop = ~stall;
      end
      S_FULL: begin
        if (redirect)      w_load_nop = 1'b1;
        else if (hlt)      w_load_nop = ~stall;
        else               w_take_buf = ~stall;
      end
      default:             w_load_nop = redirect | ~stall;
    endcase
  end

  // Output register, skid buffer, pc and control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_pend_pc   <= RESET_PC;
      r_buf_instr <= NOP_INSTR;
      r_buf_pcinc <= 16'h0000;
      r_instr     <= NOP_INSTR;
      r_pcinc     <= 16'h0000;
    end else begin
      if (w_take_mem) begin
        r_instr <= imem_data;
        r_pcinc <= w_pc_inc;
      end else if (w_take_buf) begin
        r_instr <= r_buf_instr;
        r_pcinc <= r_buf_pcinc;
      end else if (w_load_nop) begin
        r_instr <= NOP_INSTR;
        r_pcinc <= 16'h0000;
      end

      case (r_state)
        S_FETCH: begin
          if (redirect) begin
            // An unanswered request cannot be withdrawn: park the target
            // and swallow the in-flight return in DROP.
            if (imem_rdy) r_pc <= redirect_pc;
            else begin
              r_pend_pc <= redirect_pc;
              r_state   <= S_DROP;
            end
          end else if (hlt) begin
            r_state <= imem_rdy ? S_HALT : S_HALT_WAIT;
          end else if (imem_rdy) begin
            r_pc <= w_pc_inc;
            if (stall) begin
              r_buf_instr <= imem_data;
              r_buf_pcinc <= w_pc_inc;
              r_state     <= S_FULL;
            end
          end
        end
        S_DROP: begin
          if (redirect) r_pend_pc <= redirect_pc;
          if (imem_rdy) begin
            r_pc    <= redirect ? redirect_pc : r_pend_pc;
            r_state <= (!redirect && hlt) ? S_HALT : S_FETCH;
          end else if (!redirect && hlt) begin
            r_state <= S_HALT_WAIT;
          end
        end
        S_FULL: begin
          if (redirect) begin
            r_pc    <= redirect_pc;
            r_state <= S_FETCH;
          end else if (hlt) begin
            r_state <= S_HALT;
          end else if (!stall) begin
            r_state <= S_FETCH;
          end
        end
        S_HALT_WAIT: begin
          if (imem_rdy) r_state <= S_HALT;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_bubble_cnt;

  assign fetch_cnt  = r_fetch_cnt;
  assign bubble_cnt = r_bubble_cnt;

  // Saturating delivery / bubble counters, frozen once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt  <= 16'h0000;
      r_bubble_cnt <= 16'h0000;
    end else if (r_state != S_HALT) begin
      if ((w_take_mem | w_take_buf) && r_fetch_cnt != 16'hFFFF)
        r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (w_load_nop && !stall && r_bubble_cnt != 16'hFFFF)
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end
`endif

endmodule
